// File: rtl/i8088_bus_pkg.sv
// Shared types and constants for the 8088-style bus initiator.
// The state enum is one-hot so each bus phase maps to a single flop.
package i8088_bus_pkg;

    localparam int ADDR_W           = 20;
    localparam int DATA_W           = 8;
    localparam int MAX_WAIT_DEFAULT = 15;

    typedef enum logic [5:0] {
        ST_TI = 6'b000001,
        ST_T1 = 6'b000010,
        ST_T2 = 6'b000100,
        ST_T3 = 6'b001000,
        ST_TW = 6'b010000,
        ST_T4 = 6'b100000
    } bus_state_t;

    // True in the phases where the target may end the data transfer.
    function automatic logic is_xfer_end_state(input bus_state_t s);
        return (s == ST_T3) || (s == ST_TW);
    endfunction

endpackage

// File: rtl/i8088_bus_initiator.sv
// Host-request to 8088 minimum-mode bus cycle initiator (T1..T4 with wait states).
// All bus outputs are registered from the next state so they change cleanly on CLK.
module i8088_bus_initiator
    import i8088_bus_pkg::*;
#(
    parameter int MAX_WAIT  = MAX_WAIT_DEFAULT,
    parameter bit IDLE_AD_Z = 1'b1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic                cmd_io,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                ALE,
    output logic                RD,
    output logic                WR,
    output logic                IOM,
    output logic                DTR,
    output logic                DEN,
    inout  wire  [DATA_W-1:0]   AD,
    output logic [11:0]         A,
    input  logic                READY
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    bus_state_t          state_r;
    bus_state_t          state_next_s;
    logic                accept_s;
    logic                timeout_s;

    logic                cmd_we_r;
    logic                cmd_io_r;
    logic [ADDR_W-1:0]   cmd_addr_r;
    logic [DATA_W-1:0]   cmd_wdata_r;
    logic [WAIT_W-1:0]   wait_cnt_r;

    // On the accepting edge the latches are not yet loaded, so use the live inputs.
    logic                cur_we_s;
    logic                cur_io_s;
    logic [ADDR_W-1:0]   cur_addr_s;
    logic [DATA_W-1:0]   cur_wdata_s;

    logic                cmd_ready_r;
    logic                rsp_valid_r;
    logic                rsp_err_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                ale_r, rd_r, wr_r, den_r, iom_r, dtr_r;
    logic [11:0]         a_r;
    logic                ad_oe_r;
    logic [DATA_W-1:0]   ad_out_r;
    logic                ad_driven_r;

    logic                ale_s, rd_s, wr_s, den_s, iom_s, dtr_s;
    logic [11:0]         a_s;
    logic                ad_oe_s;
    logic [DATA_W-1:0]   ad_out_s;

    assign cur_we_s    = accept_s ? cmd_we    : cmd_we_r;
    assign cur_io_s    = accept_s ? cmd_io    : cmd_io_r;
    assign cur_addr_s  = accept_s ? cmd_addr  : cmd_addr_r;
    assign cur_wdata_s = accept_s ? cmd_wdata : cmd_wdata_r;

    // Bus phase sequencing and wait-state timeout decision.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_TI: begin
                if (cmd_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_T1;
                end else begin
                    state_next_s = ST_TI;
                end
            end
            ST_T1: state_next_s = ST_T2;
            ST_T2: state_next_s = ST_T3;
            ST_T3, ST_TW: begin
                if (READY) begin
                    state_next_s = ST_T4;
                end else if (wait_cnt_r == MAX_WAIT_C) begin
                    state_next_s = ST_T4;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = ST_TW;
                end
            end
            ST_T4:   state_next_s = ST_TI;
            default: state_next_s = ST_TI;
        endcase
    end

    // Bus pin values for the phase being entered; Ti holds address/qualifiers.
    always_comb begin
        ale_s    = 1'b0;
        rd_s     = 1'b1;
        wr_s     = 1'b1;
        den_s    = 1'b1;
        iom_s    = iom_r;
        dtr_s    = dtr_r;
        a_s      = a_r;
        ad_oe_s  = IDLE_AD_Z ? 1'b0 : ad_driven_r;
        ad_out_s = ad_out_r;
        case (state_next_s)
            ST_T1: begin
                ale_s    = 1'b1;
                iom_s    = cur_io_s;
                dtr_s    = cur_we_s;
                a_s      = cur_addr_s[19:8];
                ad_oe_s  = 1'b1;
                ad_out_s = cur_addr_s[7:0];
            end
            ST_T2, ST_T3, ST_TW: begin
                den_s    = 1'b0;
                rd_s     = cur_we_s;
                wr_s     = ~cur_we_s;
                ad_oe_s  = cur_we_s;
                ad_out_s = cur_we_s ? cur_wdata_s : ad_out_r;
            end
            ST_T4: begin
                ad_oe_s  = cur_we_s;
                ad_out_s = cur_we_s ? cur_wdata_s : ad_out_r;
            end
            ST_TI: begin
                ale_s = 1'b0;
            end
            default: begin
                ale_s = 1'b0;
            end
        endcase
    end

    // State, command latches and wait counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_TI;
            cmd_we_r    <= 1'b0;
            cmd_io_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_wdata_r <= {DATA_W{1'b0}};
            wait_cnt_r  <= {WAIT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                cmd_we_r    <= cmd_we;
                cmd_io_r    <= cmd_io;
                cmd_addr_r  <= cmd_addr;
                cmd_wdata_r <= cmd_wdata;
            end
            if (state_r == ST_T2) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (state_next_s == ST_TW) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
        end
    end

    // Registered host handshake, response and bus pin outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            ale_r       <= 1'b0;
            rd_r        <= 1'b1;
            wr_r        <= 1'b1;
            den_r       <= 1'b1;
            iom_r       <= 1'b0;
            dtr_r       <= 1'b0;
            a_r         <= 12'h000;
            ad_oe_r     <= 1'b0;
            ad_out_r    <= {DATA_W{1'b0}};
            ad_driven_r <= 1'b0;
        end else begin
            cmd_ready_r <= (state_next_s == ST_TI);
            rsp_valid_r <= (state_next_s == ST_T4);
            rsp_err_r   <= (state_next_s == ST_T4) && timeout_s;
            if (is_xfer_end_state(state_r) && (state_next_s == ST_T4) && !cmd_we_r) begin
                rsp_rdata_r <= timeout_s ? 8'hFF : AD;
            end
            ale_r       <= ale_s;
            rd_r        <= rd_s;
            wr_r        <= wr_s;
            den_r       <= den_s;
            iom_r       <= iom_s;
            dtr_r       <= dtr_s;
            a_r         <= a_s;
            ad_oe_r     <= ad_oe_s;
            ad_out_r    <= ad_out_s;
            ad_driven_r <= ad_driven_r | ad_oe_s;
        end
    end

    assign AD        = ad_oe_r ? ad_out_r : {DATA_W{1'bz}};
    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign ALE       = ale_r;
    assign RD        = rd_r;
    assign WR        = wr_r;
    assign DEN       = den_r;
    assign IOM       = iom_r;
    assign DTR       = dtr_r;
    assign A         = a_r;

endmodule

// File: tb/tb_i8088_bus_initiator.sv
// Self-checking bench: each transaction's expected phase list (T1,T2,T3,TW*W,T4)
// is derived from the wait-state rules, then every cycle's pins are compared.
module tb_i8088_bus_initiator;

    localparam int MW = 4;
    localparam int P_T1 = 1, P_T2 = 2, P_T3 = 3, P_TW = 4, P_T4 = 5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic        cmd_io = 1'b0;
    logic [19:0] cmd_addr = 20'h0;
    logic [7:0]  cmd_wdata = 8'h0;
    logic        READY = 1'b1;
    logic [7:0]  tgt_data = 8'h0;

    wire         cmd_ready, rsp_valid, rsp_err;
    wire  [7:0]  rsp_rdata;
    wire         ALE, RD, WR, IOM, DTR, DEN;
    wire  [11:0] A;
    wire  [7:0]  AD;

    int checks = 0;
    int fails  = 0;

    // Target model: drives read data whenever the read strobe is active.
    assign AD = (RD == 1'b0) ? tgt_data : 8'bz;

    always #5 CLK = ~CLK;

    i8088_bus_initiator #(.MAX_WAIT(MW), .IDLE_AD_Z(1'b1)) dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_io(cmd_io),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .DTR(DTR), .DEN(DEN),
        .AD(AD), .A(A), .READY(READY)
    );

    // One bus transaction; k = consecutive READY-low cycles from T3 onwards,
    // abort_at = cycle index (0 = T1) at which RESET is raised, -1 for none.
    task automatic run_txn(input logic we, input logic io, input logic [19:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rdata,
                           input int k, input int abort_at, input logic hold);
        int q[$];
        int w, n, ph;
        logic err, strobe;
        logic [18:0] exp_v, obs_v;
        logic [7:0] exp_rd;
        err = (k > MW);
        w   = err ? MW : k;
        q   = {P_T1, P_T2, P_T3};
        for (int i = 0; i < w; i++) q.push_back(P_TW);
        q.push_back(P_T4);
        exp_rd = err ? 8'hFF : rdata;
        tgt_data = rdata;

        @(negedge CLK);
        cmd_valid = 1'b1; cmd_we = we; cmd_io = io; cmd_addr = addr; cmd_wdata = wdata;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1 || n > 1) begin
            fails++;
            $display("FAIL accept: cmd_ready=%b after %0d waits, required 1 within 1", cmd_ready, n);
        end
        @(posedge CLK); #1;
        cmd_valid = hold;
        {cmd_we, cmd_io, cmd_addr, cmd_wdata} = 30'($urandom);

        for (int c = 0; c < q.size(); c++) begin
            ph     = q[c];
            strobe = (ph == P_T2) || (ph == P_T3) || (ph == P_TW);
            exp_v  = {ph == P_T1, !(strobe && !we), !(strobe && we), !strobe,
                      io, we, addr[19:8], ph == P_T4, 1'b0};
            obs_v  = {ALE, RD, WR, DEN, IOM, DTR, A, rsp_valid, cmd_ready};
            checks++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("FAIL bus_pins cyc=%0d phase=%0d got=%h required=%h", c, ph, obs_v, exp_v);
            end
            if (ph == P_T1 || we) begin
                checks++;
                if (AD !== ((ph == P_T1) ? addr[7:0] : wdata)) begin
                    fails++;
                    $display("FAIL ad_value cyc=%0d phase=%0d got=%h required=%h", c, ph, AD,
                             (ph == P_T1) ? addr[7:0] : wdata);
                end
            end
            if (ph == P_T4) begin
                checks++;
                if (rsp_err !== err) begin
                    fails++;
                    $display("FAIL rsp_err got=%b required=%b", rsp_err, err);
                end
                if (!we) begin
                    checks++;
                    if (rsp_rdata !== exp_rd) begin
                        fails++;
                        $display("FAIL rsp_rdata got=%h required=%h", rsp_rdata, exp_rd);
                    end
                end
            end
            if (ph == P_T3 || ph == P_TW) READY = ((c - 2) < k) ? 1'b0 : 1'b1;
            else READY = 1'($urandom);
            if (c == abort_at) begin
                RESET = 1'b1;
                @(posedge CLK); #1;
                RESET = 1'b0;
                checks++;
                if ({ALE, RD, WR, DEN, rsp_valid, rsp_err, cmd_ready} !== 7'b0111001) begin
                    fails++;
                    $display("FAIL abort_state got=%b required=0111001",
                             {ALE, RD, WR, DEN, rsp_valid, rsp_err, cmd_ready});
                end
                for (int j = 0; j < 3; j++) begin
                    @(posedge CLK); #1;
                    checks++;
                    if (rsp_valid !== 1'b0 || WR !== 1'b1) begin
                        fails++;
                        $display("FAIL abort_quiet cyc=%0d rsp_valid=%b WR=%b required 0/1", j, rsp_valid, WR);
                    end
                end
                return;
            end
            @(posedge CLK); #1;
        end
        checks++;
        if ({cmd_ready, rsp_valid, RD, WR, ALE} !== 5'b10110) begin
            fails++;
            $display("FAIL idle_after got=%b required=10110", {cmd_ready, rsp_valid, RD, WR, ALE});
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, ALE, RD, WR, DEN, IOM, DTR, A, rsp_rdata}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00}) begin
            fails++;
            $display("FAIL reset_values got=%b", {cmd_ready, rsp_valid, rsp_err, ALE, RD, WR, DEN,
                     IOM, DTR, A, rsp_rdata});
        end
    endtask

    task automatic test_mem_read();
        run_txn(1'b0, 1'b0, 20'h00010, 8'h00, 8'hA5, 0, -1, 1'b0);
    endtask

    task automatic test_io_write();
        run_txn(1'b1, 1'b1, 20'h00080, 8'h3C, 8'h00, 0, -1, 1'b0);
    endtask

    task automatic test_wait_read();
        run_txn(1'b0, 1'b0, 20'h12345, 8'h00, 8'h5A, 3, -1, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b1, 20'hABCDE, 8'h00, 8'h77, 8, -1, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        run_txn(1'b1, 1'b0, 20'h4F0C1, 8'hE7, 8'h00, 8, 5, 1'b0);
        run_txn(1'b0, 1'b0, 20'h00FF0, 8'h00, 8'h96, 1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 1'b0, 20'h81234, 8'h00, 8'hC3, 0, -1, 1'b1);
        run_txn(1'b1, 1'b0, 20'h08765, 8'h4B, 8'h00, 2, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            run_txn(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 6)), -1, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait_read();
        test_timeout();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        cmd_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
